// File: rtl/cap_ecc_wr_sched.sv
// Write-port scheduler for an ECC-wrapped memory: arbitrates hw/sw writers, runs the
// zero-init sweep, drives the ECC generator inputs and registers its codeword to memory.
module cap_ecc_wr_sched #(
  parameter int WIDTH        = 8,
  parameter int CODEWIDTH    = 5,
  parameter int DEPTH        = 16,
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hwWrReq,
  input  logic [ADDR_W-1:0]          hwWrAddr,
  input  logic [WIDTH-1:0]           hwWrData,
  output logic                       hwGnt,
  input  logic                       swWrReq,
  input  logic [ADDR_W-1:0]          swWrAddr,
  input  logic [WIDTH-1:0]           swWrData,
  input  logic                       swProtOverride,
  input  logic [CODEWIDTH-1:0]       swSyndrome,
  output logic                       swGnt,
  input  logic                       errInjArm,
  input  logic                       initStart,
  output logic [WIDTH-1:0]           eccRawData,
  output logic                       eccHwActive,
  output logic                       eccProtOverride,
  output logic [CODEWIDTH-1:0]       eccSyndromeOut,
  input  logic [WIDTH+CODEWIDTH-1:0] eccDataIn,
  output logic                       memWe,
  output logic [ADDR_W-1:0]          memAddr,
  output logic [WIDTH+CODEWIDTH-1:0] memWrData,
  output logic                       initDone,
  output logic                       errInjPending
);

  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STARVE_LIMIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_W-1:0]          r_initCnt;
  logic [SC_W-1:0]            r_starveCnt;
  logic                       r_memWe, r_initDone, r_errInjPending;
  logic [ADDR_W-1:0]          r_memAddr;
  logic [WIDTH+CODEWIDTH-1:0] r_memWrData;
  // Generator inputs are held between issues so they only change on a real write.
  logic [WIDTH-1:0]           r_raw;
  logic                       r_hwAct, r_prot;
  logic [CODEWIDTH-1:0]       r_syn;

  logic                       w_hwGnt, w_swGnt, w_issue, w_swForce;
  logic [ADDR_W-1:0]          w_addr;
  logic [WIDTH-1:0]           w_raw;
  logic                       w_hwAct, w_prot;
  logic [CODEWIDTH-1:0]       w_syn;

  assign w_swForce = swWrReq && (r_starveCnt == SC_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hwGnt     = 1'b0;
    w_swGnt     = 1'b0;
    w_issue     = 1'b0;
    w_addr      = r_initCnt;
    w_raw       = r_raw;
    w_hwAct     = r_hwAct;
    w_prot      = r_prot;
    w_syn       = r_syn;
    if (!rst) begin
      case (r_state)
        INIT: begin
          w_issue = 1'b1;
          w_raw   = '0;
          w_hwAct = 1'b1;
          w_prot  = 1'b0;
          w_syn   = '0;
          if (r_initCnt == LAST_ADDR) w_state_nxt = RUN;
        end
        RUN: begin
          if (hwWrReq && !w_swForce) begin
            w_hwGnt = 1'b1;
            w_issue = 1'b1;
            w_addr  = hwWrAddr;
            w_raw   = hwWrData;
            w_hwAct = 1'b1;
            w_prot  = r_errInjPending;  // generator flips bit 0, keeps clean ECC
            w_syn   = '0;
          end else if (swWrReq) begin
            w_swGnt = 1'b1;
            w_issue = 1'b1;
            w_addr  = swWrAddr;
            w_raw   = swWrData;
            w_hwAct = 1'b0;
            w_prot  = swProtOverride;
            w_syn   = swSyndrome;
          end
          if (initStart) w_state_nxt = INIT;
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memWe         <= 1'b0;
      r_memAddr       <= '0;
      r_memWrData     <= '0;
      r_initDone      <= 1'b0;
      r_errInjPending <= 1'b0;
      r_starveCnt     <= '0;
      r_initCnt       <= '0;
      r_raw           <= '0;
      r_hwAct         <= 1'b0;
      r_prot          <= 1'b0;
      r_syn           <= '0;
    end else begin
      r_memWe <= w_issue;
      if (w_issue) begin
        r_memAddr   <= w_addr;
        r_memWrData <= eccDataIn;
        r_raw       <= w_raw;
        r_hwAct     <= w_hwAct;
        r_prot      <= w_prot;
        r_syn       <= w_syn;
      end

      if (r_state == INIT) begin
        if (r_initCnt == LAST_ADDR) begin
          r_initCnt  <= '0;
          r_initDone <= 1'b1;
        end else begin
          r_initCnt <= r_initCnt + ADDR_W'(1);
        end
      end else if (initStart) begin
        r_initCnt  <= '0;
        r_initDone <= 1'b0;
      end

      if (r_state == RUN && initStart)       r_starveCnt <= '0;
      else if (w_swGnt || !swWrReq)          r_starveCnt <= '0;
      else if (w_hwGnt && r_starveCnt != SC_MAX) r_starveCnt <= r_starveCnt + SC_W'(1);

      // Re-arm wins over consumption so an arm coinciding with a flip is not lost.
      if (errInjArm)    r_errInjPending <= 1'b1;
      else if (w_hwGnt) r_errInjPending <= 1'b0;
    end
  end

  assign hwGnt           = w_hwGnt;
  assign swGnt           = w_swGnt;
  assign eccRawData      = w_raw;
  assign eccHwActive     = w_hwAct;
  assign eccProtOverride = w_prot;
  assign eccSyndromeOut  = w_syn;
  assign memWe           = r_memWe;
  assign memAddr         = r_memAddr;
  assign memWrData       = r_memWrData;
  assign initDone        = r_initDone;
  assign errInjPending   = r_errInjPending;

endmodule

// File: doc/cap_ecc_wr_sched.md
Name: cap_ecc_wr_sched

Overview:
Write-port scheduler for an ECC-protected memory wrapper. It arbitrates a hardware write requester and a software (CPU/config) write requester onto one memory write port, and sequences a zero-initialisation sweep after reset or on demand.
It drives the inputs of the team's ECC generator (rawDataIn/hwActive/protOverride/eccSyndromeIn) and registers the generator's codeword onto the memory write bus. It also owns error-injection sequencing: software syndrome override and a one-shot hardware data-bit flip.

Parameters:
WIDTH, 8, data width
CODEWIDTH, 5, ECC code width (Hamming plus overall parity)
DEPTH, 16, memory entries; ADDR_W = log2(DEPTH), minimum 1
STARVE_LIMIT, 3, consecutive hw grants allowed while sw is pending before sw is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
hwWrReq  in  1  hw write request, held until hwGnt
hwWrAddr  in  ADDR_W  hw write address
hwWrData  in  WIDTH  hw write data
hwGnt  out  1  hw request accepted this cycle (combinational)
swWrReq  in  1  sw write request, held until swGnt
swWrAddr  in  ADDR_W  sw write address
swWrData  in  WIDTH  sw write data
swProtOverride  in  1  sw write uses swSyndrome instead of computed ECC
swSyndrome  in  CODEWIDTH  override syndrome
swGnt  out  1  sw request accepted this cycle (combinational)
errInjArm  in  1  pulse: arm a one-shot bit-0 flip on the next hw write
initStart  in  1  pulse: restart the init sweep
eccRawData  out  WIDTH  to ECC generator rawDataIn
eccHwActive  out  1  to generator hwActive
eccProtOverride  out  1  to generator protOverride
eccSyndromeOut  out  CODEWIDTH  to generator eccSyndromeIn
eccDataIn  in  WIDTH+CODEWIDTH  from generator eccDataOut, combinational
memWe  out  1  registered write enable
memAddr  out  ADDR_W  registered write address
memWrData  out  WIDTH+CODEWIDTH  registered codeword
initDone  out  1  init sweep complete
errInjPending  out  1  one-shot flip armed

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active high.
- Reset values: memWe=0, memAddr=0, memWrData=0, initDone=0, errInjPending=0, starveCnt=0, initCnt=0, state=INIT.
- hwGnt and swGnt are 0 whenever rst=1 or state=INIT.
- FSM states:
  - INIT: one write per cycle at initCnt with eccRawData=0, eccHwActive=1, eccProtOverride=0.
    - initCnt increments each cycle.
    - On initCnt=DEPTH-1: next state RUN, initDone set, initCnt cleared.
  - RUN: arbitrate the requesters.
    - initStart=1 → next state INIT, initDone cleared, initCnt=0, starveCnt=0.
    - Any grant issued in the same cycle as initStart still completes.
  - initStart while in INIT is ignored.
- Arbitration in RUN:
  - hw wins over sw, except when starveCnt==STARVE_LIMIT and swWrReq=1; then sw wins.
  - starveCnt increments on each hw grant while swWrReq=1, saturating at STARVE_LIMIT.
  - starveCnt clears on any sw grant, or when swWrReq=0.
  - At most one grant per cycle.
- Source mapping for the granted request:
  - Init: rawData=0, hwActive=1, protOverride=0, syndrome=0.
  - hw, errInjPending=0: rawData=hwWrData, hwActive=1, protOverride=0.
  - hw, errInjPending=1: same, but protOverride=1, so the generator flips data bit 0 with unmodified ECC. errInjPending clears on that grant.
  - sw: rawData=swWrData, hwActive=0, protOverride=swProtOverride, syndrome=swSyndrome.
  - No grant: outputs are held at the last value; only memWe matters.
- Error-injection arm:
  - errInjArm sets errInjPending.
  - Arm and a consuming hw grant in the same cycle: the current write is flipped and errInjPending stays 1.
  - Arm during INIT is retained.
- Latency: grant or init issue in cycle N → memWe=1 in cycle N+1, with memAddr and memWrData=eccDataIn sampled at N.
- Throughput: one write per cycle.
- Sweep timing: rst deasserted at cycle 0 → writes addr 0..DEPTH-1 appear at cycles 1..DEPTH. initDone=1 from cycle DEPTH. The first grant is possible at cycle DEPTH.
- rst mid-operation: the in-flight memWe is dropped (memWe=0 the next cycle), the sweep restarts from 0, and the arm is lost.
- Address width: initCnt wraps modulo DEPTH; non-power-of-2 DEPTH terminates at DEPTH-1.

Test Plan:
(WIDTH=8, CODEWIDTH=5, DEPTH=16, STARVE_LIMIT=3, golden ECC model on eccDataIn)
1. Release rst, no requests → memWe at cycles 1..16, memAddr 0..15, memWrData=13'h0000; initDone=1 at cycle 16; no grants before cycle 16.
2. hwWrReq and swWrReq held high in RUN → grant sequence hw,hw,hw,sw repeating; starveCnt returns to 0 after each sw grant.
3. sw write addr 5, data 8'hA5, swProtOverride=1, swSyndrome=5'h1F → next cycle memWe=1, memAddr=5, memWrData=13'h1FA5.
4. errInjArm pulse, then hw write addr 3, data 8'h00 → memWrData=13'h0001 and errInjPending drops; the following hw write of 8'h00 gives 13'h0000.
5. initStart pulse in RUN with hwWrReq held → hwGnt=0 for 16 cycles of sweep; hw granted in the cycle initDone rises.
6. Assert rst for one cycle during INIT after addr 7 is issued → memWe=0 the following cycle, initDone=0, and the sweep restarts at addr 0 with 16 full writes.
